// File: rtl/operand_fetch_seq.sv
// Operand / effective-address sequencer for the 6502 datapath.
// Walks pointer fetches, index add, page-cross fix-up and the final operand read.
module operand_fetch_seq #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned ZP_WRAP      = 1,
  parameter int unsigned PAGE_PENALTY = 1,
  parameter int unsigned IND_PAGE_BUG = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [3:0]        mode_i,
  input  logic [15:0]       operand_i,
  input  logic [7:0]        x_i,
  input  logic [7:0]        y_i,
  input  logic              is_store_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              block_pc_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] ea_o,
  output logic [7:0]        data_o,
  output logic              page_cross_o
);

  localparam int unsigned MODE_W = 4;
  localparam int unsigned OP_W   = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [MODE_W-1:0] M_IMPL = 4'd0;
  localparam logic [MODE_W-1:0] M_IMM  = 4'd1;
  localparam logic [MODE_W-1:0] M_ZP   = 4'd2;
  localparam logic [MODE_W-1:0] M_ZPX  = 4'd3;
  localparam logic [MODE_W-1:0] M_ZPY  = 4'd4;
  localparam logic [MODE_W-1:0] M_ABS  = 4'd5;
  localparam logic [MODE_W-1:0] M_ABSX = 4'd6;
  localparam logic [MODE_W-1:0] M_ABSY = 4'd7;
  localparam logic [MODE_W-1:0] M_IND  = 4'd8;
  localparam logic [MODE_W-1:0] M_INDX = 4'd9;
  localparam logic [MODE_W-1:0] M_INDY = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PTR_LO = 3'd1,
    S_PTR_HI = 3'd2,
    S_FIX    = 3'd3,
    S_READ   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Instruction fields captured on the accepted start
  logic [MODE_W-1:0] mode_q;
  logic [OP_W-1:0]   op_q;
  logic [BYTE_W-1:0] x_q, y_q;
  logic              store_q;

  logic [BYTE_W-1:0] lo_q, lo_d;
  logic [OP_W-1:0]   eff_q, eff_d;
  logic              cross_q, cross_d;
  logic [OP_W-1:0]   addr_q, addr_d;

  logic              req_q, busy_q, done_q, err_q, pc_q;
  logic [OP_W-1:0]   ea_q;
  logic [BYTE_W-1:0] data_q;

  logic              addr_ready, fin, fin_pc, err_d, mem_d;
  logic [OP_W-1:0]   fin_ea;
  logic [BYTE_W-1:0] fin_data;

  // In IDLE the live inputs drive the decode so the first step costs no extra cycle
  logic              cap;
  logic [MODE_W-1:0] m;
  logic [OP_W-1:0]   op;
  logic [BYTE_W-1:0] xv, yv, idx;
  logic              st;

  assign cap = (state_q == S_IDLE);
  assign m   = cap ? mode_i     : mode_q;
  assign op  = cap ? operand_i  : op_q;
  assign xv  = cap ? x_i        : x_q;
  assign yv  = cap ? y_i        : y_q;
  assign st  = cap ? is_store_i : store_q;
  assign idx = ((m == M_ZPX) || (m == M_ABSX)) ? xv : yv;

  logic [8:0]        zp_sum9;
  logic [OP_W-1:0]   zp_ea, abs_sum, ptr_lo_addr, ptr_hi_addr, ptr_word, indy_sum;
  logic [BYTE_W-1:0] ptr_base;
  logic              abs_cross, indy_cross, store_fix_mode;

  assign zp_sum9   = {1'b0, op[7:0]} + {1'b0, idx};
  assign zp_ea     = (ZP_WRAP != 0) ? {8'h00, zp_sum9[7:0]} : {7'h00, zp_sum9};
  assign abs_sum   = op + {8'h00, idx};
  assign abs_cross = (abs_sum[15:8] != op[15:8]);

  // Pointer addresses; IND optionally reproduces the NMOS page-wrap quirk
  assign ptr_base    = (m == M_INDX) ? op[7:0] + xv : op[7:0];
  assign ptr_lo_addr = (m == M_IND) ? op : {8'h00, ptr_base};
  assign ptr_hi_addr = (m == M_IND)
                       ? ((IND_PAGE_BUG != 0) ? {op[15:8], op[7:0] + 8'd1} : op + 16'd1)
                       : {8'h00, ptr_base + 8'd1};

  assign ptr_word   = {mem_rdata_i, lo_q};
  assign indy_sum   = ptr_word + {8'h00, yv};
  assign indy_cross = (indy_sum[15:8] != mem_rdata_i);

  assign store_fix_mode = (m == M_ABSX) || (m == M_ABSY) || (m == M_INDY);

  // Next-state and step decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lo_d       = lo_q;
    eff_d      = eff_q;
    cross_d    = cross_q;
    addr_ready = 1'b0;
    fin        = 1'b0;
    fin_ea     = ea_q;
    fin_data   = data_q;
    fin_pc     = pc_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          case (m)
            M_IMPL: begin
              state_d  = S_DONE;
              fin      = 1'b1;
              fin_ea   = '0;
              fin_data = '0;
              fin_pc   = 1'b0;
            end
            M_IMM: begin
              state_d  = S_DONE;
              fin      = 1'b1;
              fin_ea   = '0;
              fin_data = op[7:0];
              fin_pc   = 1'b0;
            end
            M_ZP: begin
              eff_d      = {8'h00, op[7:0]};
              cross_d    = 1'b0;
              addr_ready = 1'b1;
            end
            M_ZPX, M_ZPY: begin
              eff_d      = zp_ea;
              cross_d    = 1'b0;
              addr_ready = 1'b1;
            end
            M_ABS: begin
              eff_d      = op;
              cross_d    = 1'b0;
              addr_ready = 1'b1;
            end
            M_ABSX, M_ABSY: begin
              eff_d      = abs_sum;
              cross_d    = abs_cross;
              addr_ready = 1'b1;
            end
            M_IND, M_INDX, M_INDY: begin
              state_d = S_PTR_LO;
              addr_d  = ptr_lo_addr;
              cross_d = 1'b0;
            end
            default: begin
              state_d  = S_DONE;
              fin      = 1'b1;
              fin_ea   = '0;
              fin_data = '0;
              fin_pc   = 1'b0;
              err_d    = 1'b1;
            end
          endcase
        end
      end
      S_PTR_LO: begin
        if (mem_valid_i) begin
          lo_d    = mem_rdata_i;
          state_d = S_PTR_HI;
          addr_d  = ptr_hi_addr;
        end
      end
      S_PTR_HI: begin
        if (mem_valid_i) begin
          if (m == M_INDY) begin
            eff_d   = indy_sum;
            cross_d = indy_cross;
          end else begin
            eff_d   = ptr_word;
            cross_d = 1'b0;
          end
          addr_ready = 1'b1;
        end
      end
      S_FIX: begin
        if (st) begin
          state_d  = S_DONE;
          fin      = 1'b1;
          fin_ea   = eff_q;
          fin_data = '0;
          fin_pc   = cross_q;
        end else begin
          state_d = S_READ;
          addr_d  = eff_q;
        end
      end
      S_READ: begin
        if (mem_valid_i) begin
          state_d  = S_DONE;
          fin      = 1'b1;
          fin_ea   = eff_q;
          fin_data = mem_rdata_i;
          fin_pc   = cross_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Address known: optional fix-up cycle, then final read or finish
    if (addr_ready) begin
      if ((PAGE_PENALTY != 0) && (cross_d || (st && store_fix_mode))) begin
        state_d = S_FIX;
      end else if (st || (m == M_IND)) begin
        state_d  = S_DONE;
        fin      = 1'b1;
        fin_ea   = eff_d;
        fin_data = '0;
        fin_pc   = cross_d;
      end else begin
        state_d = S_READ;
        addr_d  = eff_d;
      end
    end
  end

  assign mem_d = (state_d == S_PTR_LO) || (state_d == S_PTR_HI) || (state_d == S_READ);

  // State, captured fields and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      store_q <= 1'b0;
      lo_q    <= '0;
      eff_q   <= '0;
      cross_q <= 1'b0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ea_q    <= '0;
      data_q  <= '0;
      pc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap && start_i) begin
        mode_q  <= mode_i;
        op_q    <= operand_i;
        x_q     <= x_i;
        y_q     <= y_i;
        store_q <= is_store_i;
      end
      lo_q    <= lo_d;
      eff_q   <= eff_d;
      cross_q <= cross_d;
      addr_q  <= mem_d ? addr_d : '0;
      req_q   <= mem_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_d;
      if (fin) begin
        ea_q   <= fin_ea;
        data_q <= fin_data;
        pc_q   <= fin_pc;
      end
    end
  end

  assign mem_req_o    = req_q;
  assign mem_addr_o   = ADDR_W'(addr_q);
  assign busy_o       = busy_q;
  assign block_pc_o   = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign ea_o         = ADDR_W'(ea_q);
  assign data_o       = data_q;
  assign page_cross_o = pc_q;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Bench for operand_fetch_seq: two parameterisations checked every cycle against
// a transaction-level model, plus directed cases with literal expectations.
module tb_operand_fetch_seq;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        start_i, is_store_i, mem_valid_i;
  logic [3:0]  mode_i;
  logic [15:0] operand_i;
  logic [7:0]  x_i, y_i;

  logic        req[2], busy[2], bpc[2], done[2], err[2], pc[2];
  logic [15:0] addr[2], ea[2];
  logic [7:0]  rdata[2], data[2];

  logic [7:0]  mem [0:65535];
  logic [7:0]  junk;

  assign rdata[0] = mem_valid_i ? mem[addr[0]] : junk;
  assign rdata[1] = mem_valid_i ? mem[addr[1]] : junk;

  operand_fetch_seq #(.ADDR_W(16), .ZP_WRAP(1), .PAGE_PENALTY(1), .IND_PAGE_BUG(1)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_i), .mode_i(mode_i), .operand_i(operand_i),
    .x_i(x_i), .y_i(y_i), .is_store_i(is_store_i), .mem_req_o(req[0]), .mem_addr_o(addr[0]),
    .mem_valid_i(mem_valid_i), .mem_rdata_i(rdata[0]), .busy_o(busy[0]), .block_pc_o(bpc[0]),
    .done_o(done[0]), .err_o(err[0]), .ea_o(ea[0]), .data_o(data[0]), .page_cross_o(pc[0]));

  operand_fetch_seq #(.ADDR_W(16), .ZP_WRAP(0), .PAGE_PENALTY(0), .IND_PAGE_BUG(0)) dut_alt (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_i), .mode_i(mode_i), .operand_i(operand_i),
    .x_i(x_i), .y_i(y_i), .is_store_i(is_store_i), .mem_req_o(req[1]), .mem_addr_o(addr[1]),
    .mem_valid_i(mem_valid_i), .mem_rdata_i(rdata[1]), .busy_o(busy[1]), .block_pc_o(bpc[1]),
    .done_o(done[1]), .err_o(err[1]), .ea_o(ea[1]), .data_o(data[1]), .page_cross_o(pc[1]));

  int npass = 0;
  int ncheck = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Model: per start, the list of steps (memory address, -1 fix cycle, -2 done)
  localparam int STEP_FIX  = -1;
  localparam int STEP_DONE = -2;
  bit          mbusy[2];
  int          steps[2][8];
  int          nst[2], pos[2];
  logic [15:0] hea[2], nea[2];
  logic [7:0]  hdat[2], ndat[2];
  bit          hpc[2], npc[2], nerr[2];

  function automatic void push(input int i, input int v);
    steps[i][nst[i]] = v;
    nst[i]++;
  endfunction

  function automatic void build(input int i);
    bit zw = (i == 0);
    bit pp = (i == 0);
    bit ib = (i == 0);
    int m = int'(mode_i);
    int op = int'(operand_i);
    int x = int'(x_i);
    int y = int'(y_i);
    bit st = is_store_i;
    int eav = 0, dv = 0, lo = 0, hi = 0, base = 0, s = 0;
    bit pcv = 0, errv = 0, addr_mode = 0, indexed = 0;
    nst[i] = 0;
    pos[i] = 0;
    case (m)
      0: ;
      1: dv = op & 255;
      2: begin eav = op & 255; addr_mode = 1; end
      3, 4: begin
        s = (op & 255) + ((m == 3) ? x : y);
        eav = zw ? (s & 255) : s;
        addr_mode = 1;
      end
      5: begin eav = op; addr_mode = 1; end
      6, 7: begin
        eav = (op + ((m == 6) ? x : y)) & 65535;
        pcv = ((eav >> 8) != (op >> 8));
        indexed = 1;
        addr_mode = 1;
      end
      8: begin
        lo = op;
        hi = ib ? ((op & 16'hFF00) | ((op + 1) & 255)) : ((op + 1) & 65535);
        push(i, lo); push(i, hi);
        eav = int'(mem[hi]) * 256 + int'(mem[lo]);
      end
      9: begin
        lo = (op + x) & 255;
        hi = (lo + 1) & 255;
        push(i, lo); push(i, hi);
        eav = int'(mem[hi]) * 256 + int'(mem[lo]);
        addr_mode = 1;
      end
      10: begin
        lo = op & 255;
        hi = (lo + 1) & 255;
        push(i, lo); push(i, hi);
        base = int'(mem[hi]) * 256 + int'(mem[lo]);
        eav = (base + y) & 65535;
        pcv = ((eav >> 8) != (base >> 8));
        indexed = 1;
        addr_mode = 1;
      end
      default: errv = 1;
    endcase
    if (addr_mode) begin
      if (pp && (pcv || (st && indexed))) push(i, STEP_FIX);
      if (!st) begin
        push(i, eav);
        dv = int'(mem[eav]);
      end
    end
    push(i, STEP_DONE);
    nea[i]  = 16'(eav);
    ndat[i] = 8'(dv);
    npc[i]  = pcv;
    nerr[i] = errv;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        mbusy[i] = 0; hea[i] = '0; hdat[i] = '0; hpc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!mbusy[i]) begin
          if (start_i) begin
            build(i);
            mbusy[i] = 1;
          end
        end else if (steps[i][pos[i]] == STEP_DONE) begin
          mbusy[i] = 0;
          hea[i] = nea[i]; hdat[i] = ndat[i]; hpc[i] = npc[i];
        end else if (steps[i][pos[i]] == STEP_FIX || mem_valid_i) begin
          pos[i]++;
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 2; i++) begin
        int  s;
        bit  e_req, e_done;
        s      = mbusy[i] ? steps[i][pos[i]] : -3;
        e_req  = (s >= 0);
        e_done = (s == STEP_DONE);
        chk($sformatf("i%0d busy", i), 32'(busy[i]), 32'(mbusy[i]));
        chk($sformatf("i%0d block_pc", i), 32'(bpc[i]), 32'(mbusy[i]));
        chk($sformatf("i%0d req", i), 32'(req[i]), 32'(e_req));
        if (e_req) chk($sformatf("i%0d addr", i), 32'(addr[i]), 32'(s));
        chk($sformatf("i%0d done", i), 32'(done[i]), 32'(e_done));
        chk($sformatf("i%0d err", i), 32'(err[i]), 32'(e_done && nerr[i]));
        chk($sformatf("i%0d ea", i), 32'(ea[i]), 32'(e_done ? nea[i] : hea[i]));
        chk($sformatf("i%0d data", i), 32'(data[i]), 32'(e_done ? ndat[i] : hdat[i]));
        chk($sformatf("i%0d page_cross", i), 32'(pc[i]), 32'(e_done ? npc[i] : hpc[i]));
      end
    end
  end

  // Memory valid: 0 always ready, 1 random waits, 2 two waits per access
  int vmode = 0;
  int wcnt = 0;
  always @(negedge clk) begin
    junk = 8'($urandom);
    case (vmode)
      0: mem_valid_i = 1'b1;
      1: mem_valid_i = ($urandom_range(0, 3) != 0);
      default: begin
        if (!req[0]) begin
          wcnt = 0; mem_valid_i = 1'b0;
        end else if (wcnt == 2) begin
          wcnt = 0; mem_valid_i = 1'b1;
        end else begin
          wcnt++; mem_valid_i = 1'b0;
        end
      end
    endcase
  end

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while ((mbusy[0] || mbusy[1]) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("idle wait timeout", 32'(g), 32'(0));
  endtask

  task automatic run_dir(input string nm, input int sel, input logic [3:0] md,
                         input logic [15:0] op, input logic [7:0] xv, input logic [7:0] yv,
                         input logic st, input int ecyc, input logic [15:0] eea,
                         input logic [7:0] edat, input logic epc, input logic eerr,
                         input int pulse_at, output int busyc, output bit sawreq);
    int n;
    wait_idle();
    mode_i = md; operand_i = op; x_i = xv; y_i = yv; is_store_i = st; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    mode_i = 4'($urandom); operand_i = 16'($urandom);
    x_i = 8'($urandom); y_i = 8'($urandom); is_store_i = ~st;
    n = 1; busyc = 0; sawreq = 0;
    while (!done[sel] && n < 60) begin
      busyc += int'(busy[sel]);
      sawreq |= req[sel];
      start_i = (n == pulse_at);
      @(negedge clk);
      start_i = 1'b0;
      n++;
    end
    busyc += int'(busy[sel]);
    sawreq |= req[sel];
    chk({nm, " cycles"}, 32'(n), 32'(ecyc));
    chk({nm, " ea"}, 32'(ea[sel]), 32'(eea));
    chk({nm, " data"}, 32'(data[sel]), 32'(edat));
    chk({nm, " page_cross"}, 32'(pc[sel]), 32'(epc));
    chk({nm, " err"}, 32'(err[sel]), 32'(eerr));
  endtask

  initial begin
    int  bc;
    bit  sr;
    rstn = 1'b0; start_i = 1'b0; mode_i = '0; operand_i = '0; x_i = '0; y_i = '0;
    is_store_i = 1'b0; mem_valid_i = 1'b1;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'h0010] = 8'h5A; mem[16'h0110] = 8'hC3;
    mem[16'h1310] = 8'h77; mem[16'h12F5] = 8'h66;
    mem[16'h30FF] = 8'h80; mem[16'h3000] = 8'h50; mem[16'h3100] = 8'h61;
    mem[16'h0040] = 8'h10; mem[16'h0041] = 8'h20; mem[16'h2015] = 8'h99;
    mem[16'h1234] = 8'hAB;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d reset outputs", i),
          {9'(0), busy[i], bpc[i], req[i], done[i], err[i], pc[i], data[i], 8'(0)}, 32'(0));
      chk($sformatf("i%0d reset ea/addr", i), {ea[i], addr[i]}, 32'(0));
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    run_dir("imm", 0, 4'd1, 16'h0042, 8'h00, 8'h00, 1'b0, 1, 16'h0000, 8'h42, 1'b0, 1'b0, 0, bc, sr);
    chk("imm busy cycles", 32'(bc), 32'(1));
    chk("imm no request", 32'(sr), 32'(0));
    run_dir("zpx wrap", 0, 4'd3, 16'h00F0, 8'h20, 8'h00, 1'b0, 2, 16'h0010, 8'h5A, 1'b0, 1'b0, 0, bc, sr);
    run_dir("zpx nowrap", 1, 4'd3, 16'h00F0, 8'h20, 8'h00, 1'b0, 2, 16'h0110, 8'hC3, 1'b0, 1'b0, 0, bc, sr);
    run_dir("absy cross", 0, 4'd7, 16'h12F0, 8'h00, 8'h20, 1'b0, 3, 16'h1310, 8'h77, 1'b1, 1'b0, 0, bc, sr);
    run_dir("absy cross nopen", 1, 4'd7, 16'h12F0, 8'h00, 8'h20, 1'b0, 2, 16'h1310, 8'h77, 1'b1, 1'b0, 0, bc, sr);
    run_dir("absy nocross", 0, 4'd7, 16'h12F0, 8'h00, 8'h05, 1'b0, 2, 16'h12F5, 8'h66, 1'b0, 1'b0, 0, bc, sr);
    run_dir("ind bug", 0, 4'd8, 16'h30FF, 8'h00, 8'h00, 1'b0, 3, 16'h5080, 8'h00, 1'b0, 1'b0, 0, bc, sr);
    run_dir("ind nobug", 1, 4'd8, 16'h30FF, 8'h00, 8'h00, 1'b0, 3, 16'h6180, 8'h00, 1'b0, 1'b0, 0, bc, sr);
    run_dir("absx store", 0, 4'd6, 16'h2000, 8'h01, 8'h00, 1'b1, 2, 16'h2001, 8'h00, 1'b0, 1'b0, 0, bc, sr);
    run_dir("absx store nopen", 1, 4'd6, 16'h2000, 8'h01, 8'h00, 1'b1, 1, 16'h2001, 8'h00, 1'b0, 1'b0, 0, bc, sr);
    run_dir("illegal", 0, 4'd12, 16'hBEEF, 8'h00, 8'h00, 1'b0, 1, 16'h0000, 8'h00, 1'b0, 1'b1, 0, bc, sr);
    vmode = 2;
    run_dir("indy waits", 0, 4'd10, 16'h0040, 8'h00, 8'h05, 1'b0, 10, 16'h2015, 8'h99, 1'b0, 1'b0, 3, bc, sr);
    vmode = 0;

    // Reset while the IND sequence sits in its high-pointer fetch
    wait_idle();
    mode_i = 4'd8; operand_i = 16'h30FF; is_store_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("ptr_hi req", 32'(req[0]), 32'(1));
    chk("ptr_hi addr", 32'(addr[0]), 32'(16'h3000));
    #2 rstn = 1'b0;
    #1;
    chk("async reset flags",
        {9'(0), busy[0], bpc[0], req[0], done[0], err[0], pc[0], data[0], 8'(0)}, 32'(0));
    chk("async reset ea/addr", {ea[0], addr[0]}, 32'(0));
    @(negedge clk);
    rstn = 1'b1;
    run_dir("abs after reset", 0, 4'd5, 16'h1234, 8'h00, 8'h00, 1'b0, 2, 16'h1234, 8'hAB, 1'b0, 1'b0, 0, bc, sr);

    // Random traffic with random memory wait states
    vmode = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start_i    = ($urandom_range(0, 2) == 0);
      mode_i     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      operand_i  = 16'($urandom);
      x_i        = 8'($urandom);
      y_i        = 8'($urandom);
      is_store_i = 1'($urandom);
    end
    start_i = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
